// File: rtl/photon_hls_deadlock_monitor_unit_pkg.sv
// Shared types and helpers for the photon HLS deadlock monitor.
// Holds the FSM state encoding, the process one-hot helper and the confirm-counter width.
package photon_hls_dl_pkg;

  localparam int unsigned MaxProcNum = 64;

  typedef logic [1:0] dl_state_t;
  localparam dl_state_t StIdle = 2'd0;
  localparam dl_state_t StPend = 2'd1;
  localparam dl_state_t StConf = 2'd2;

  localparam int unsigned DefaultConfirm = 16;
  localparam int unsigned DefaultCntW    = $clog2(DefaultConfirm + 1);

  function automatic int unsigned cnt_width(int unsigned confirm);
    return $clog2(confirm + 1);
  endfunction

  function automatic logic [MaxProcNum-1:0] onehot(int unsigned idx);
    return MaxProcNum'(1) << idx;
  endfunction

endpackage

// File: rtl/photon_hls_deadlock_monitor_unit_if.sv
// Dependency/token channel bundle between a deadlock monitor and its dataflow neighbours.
// The monitor connects through the slave modport; the surrounding fabric uses master.
interface photon_hls_deadlock_monitor_unit_if #(
  parameter int unsigned PROC_NUM     = 4,
  parameter int unsigned IN_CHAN_NUM  = 2,
  parameter int unsigned OUT_CHAN_NUM = 3,
  parameter int unsigned STAMP_W      = 32
);
  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec;
  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec;
  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec;
  logic [IN_CHAN_NUM-1:0]          token_in_vec;
  logic                            dl_detect_in;
  logic                            origin;
  logic                            token_clear;
  logic                            dl_clear;
  logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec;
  logic [PROC_NUM-1:0]             out_chan_dep_data;
  logic [OUT_CHAN_NUM-1:0]         token_out_vec;
  logic                            dl_detect_out;
  logic [PROC_NUM-1:0]             dl_dep_snapshot;
  logic [STAMP_W-1:0]              dl_cycle_stamp;

  modport master (
    output proc_dep_vld_vec, in_chan_dep_vld_vec, in_chan_dep_data_vec, token_in_vec,
           dl_detect_in, origin, token_clear, dl_clear,
    input  out_chan_dep_vld_vec, out_chan_dep_data, token_out_vec, dl_detect_out,
           dl_dep_snapshot, dl_cycle_stamp
  );

  modport slave (
    input  proc_dep_vld_vec, in_chan_dep_vld_vec, in_chan_dep_data_vec, token_in_vec,
           dl_detect_in, origin, token_clear, dl_clear,
    output out_chan_dep_vld_vec, out_chan_dep_data, token_out_vec, dl_detect_out,
           dl_dep_snapshot, dl_cycle_stamp
  );
endinterface

// File: rtl/photon_hls_dl_dep_merge.sv
// Merges the dependency vectors of all valid incoming channels into one OR-ed vector.
module photon_hls_dl_dep_merge #(
  parameter int unsigned PROC_NUM    = 4,
  parameter int unsigned IN_CHAN_NUM = 2
) (
  input  logic [IN_CHAN_NUM-1:0]          vld_i,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] data_i,
  output logic [PROC_NUM-1:0]             dep_comb_o
);
  always_comb begin
    dep_comb_o = '0;
    for (int i = 0; i < int'(IN_CHAN_NUM); i++) begin
      if (vld_i[i]) dep_comb_o = dep_comb_o | data_i[i*PROC_NUM +: PROC_NUM];
    end
  end
endmodule

// File: rtl/photon_hls_deadlock_monitor_unit.sv
// Per-process deadlock monitor: propagates dependency vectors, confirms persistent cycles,
// and keeps a sticky report. Define DL_MONITOR_CYCLE_STAMP_EN to add a confirmation cycle stamp.
module photon_hls_deadlock_monitor_unit
  import photon_hls_dl_pkg::*;
#(
  parameter int unsigned PROC_NUM       = 4,
  parameter int unsigned PROC_ID        = 0,
  parameter int unsigned IN_CHAN_NUM    = 2,
  parameter int unsigned OUT_CHAN_NUM   = 3,
  parameter int unsigned CONFIRM_CYCLES = 16,
  parameter int unsigned STAMP_W        = 32
) (
  input logic clock,
  input logic reset,
  photon_hls_deadlock_monitor_unit_if.slave bus
);
  localparam int unsigned CntW = cnt_width(CONFIRM_CYCLES);
  localparam logic [PROC_NUM-1:0] IdMask = PROC_NUM'(onehot(PROC_ID));
  localparam logic [CntW-1:0] CntMax = CntW'(CONFIRM_CYCLES);

  logic [PROC_NUM-1:0]     dep_comb, dep_sel;
  logic [PROC_NUM-1:0]     dep_reg_d, dep_reg_q;
  logic [PROC_NUM-1:0]     snap_d, snap_q;
  logic [OUT_CHAN_NUM-1:0] token_out_d, token_out_q;
  logic [CntW-1:0]         cnt_d, cnt_q;
  dl_state_t               state_d, state_q;
  logic                    detect_d, detect_q;
  logic                    gate, raw, proc_blocked, enter_conf;

  photon_hls_dl_dep_merge #(
    .PROC_NUM   (PROC_NUM),
    .IN_CHAN_NUM(IN_CHAN_NUM)
  ) u_dep_merge (
    .vld_i     (bus.in_chan_dep_vld_vec),
    .data_i    (bus.in_chan_dep_data_vec),
    .dep_comb_o(dep_comb)
  );

  // While the region is already flagged, only a token arrival lets fresh dependencies through.
  assign gate         = ~bus.dl_detect_in | (|bus.token_in_vec);
  assign proc_blocked = |bus.proc_dep_vld_vec;
  assign dep_sel      = gate ? dep_comb : dep_reg_q;
  assign raw          = gate & (|(dep_sel & IdMask)) & proc_blocked;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (raw) begin
          cnt_d   = CntW'(1);
          state_d = (CONFIRM_CYCLES == 1) ? StConf : StPend;
        end
      end
      StPend: begin
        if (!raw) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntMax) state_d = StConf;
        end
      end
      StConf: begin
        if (bus.dl_clear) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign enter_conf  = (state_q != StConf) && (state_d == StConf);
  assign detect_d    = (state_d == StConf);
  assign snap_d      = enter_conf ? dep_sel : snap_q;
  assign dep_reg_d   = proc_blocked ? dep_sel : '0;
  // origin overrides token_clear so an originating unit always launches its token.
  assign token_out_d = (((|bus.token_in_vec) & ~bus.token_clear) | bus.origin)
                       ? bus.proc_dep_vld_vec : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      detect_q    <= 1'b0;
      snap_q      <= '0;
      dep_reg_q   <= '0;
      token_out_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      detect_q    <= detect_d;
      snap_q      <= snap_d;
      dep_reg_q   <= dep_reg_d;
      token_out_q <= token_out_d;
    end
  end

`ifdef DL_MONITOR_CYCLE_STAMP_EN
  logic [STAMP_W-1:0] stamp_cnt_d, stamp_cnt_q, stamp_d, stamp_q;

  assign stamp_cnt_d = stamp_cnt_q + STAMP_W'(1);
  assign stamp_d     = enter_conf ? stamp_cnt_q : stamp_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stamp_cnt_q <= '0;
      stamp_q     <= '0;
    end else begin
      stamp_cnt_q <= stamp_cnt_d;
      stamp_q     <= stamp_d;
    end
  end

  assign bus.dl_cycle_stamp = stamp_q;
`else
  assign bus.dl_cycle_stamp = '0;
`endif

  assign bus.out_chan_dep_vld_vec = bus.proc_dep_vld_vec;
  assign bus.out_chan_dep_data    = dep_reg_q | IdMask;
  assign bus.token_out_vec        = token_out_q;
  assign bus.dl_detect_out        = detect_q;
  assign bus.dl_dep_snapshot      = snap_q;
endmodule

// File: tb/tb_photon_hls_deadlock_monitor_unit.sv
// Self-checking bench: directed scenarios then biased random traffic against a
// run-length reference model of the deadlock monitor.
module tb_photon_hls_deadlock_monitor_unit;
  localparam int unsigned PN = 4;
  localparam int unsigned PID = 0;
  localparam int unsigned IC = 2;
  localparam int unsigned OC = 3;
  localparam int unsigned CC = 16;
  localparam int unsigned SW = 32;
  localparam int unsigned DW = IC * PN;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  photon_hls_deadlock_monitor_unit_if #(
    .PROC_NUM(PN), .IN_CHAN_NUM(IC), .OUT_CHAN_NUM(OC), .STAMP_W(SW)
  ) bus ();

  photon_hls_deadlock_monitor_unit #(
    .PROC_NUM(PN), .PROC_ID(PID), .IN_CHAN_NUM(IC), .OUT_CHAN_NUM(OC),
    .CONFIRM_CYCLES(CC), .STAMP_W(SW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Reference model: consecutive-raw run length plus a sticky confirmed flag.
  logic [PN-1:0] m_dep_reg;
  logic [PN-1:0] m_snap;
  logic [OC-1:0] m_tok;
  logic [SW-1:0] m_stamp, m_cyc;
  int            m_run;
  bit            m_conf;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dep_reg = '0; m_snap = '0; m_tok = '0; m_stamp = '0; m_cyc = '0;
    m_run = 0; m_conf = 0;
  endtask

  task automatic step();
    logic [PN-1:0] comb, sel;
    bit gate, raw;
    @(posedge clock);
    comb = '0;
    for (int i = 0; i < int'(IC); i++)
      if (bus.in_chan_dep_vld_vec[i]) comb = comb | bus.in_chan_dep_data_vec[i*PN +: PN];
    gate = !bus.dl_detect_in || (bus.token_in_vec != 0);
    sel  = gate ? comb : m_dep_reg;
    raw  = gate && sel[PID] && (bus.proc_dep_vld_vec != 0);
    if (reset) begin
      model_reset();
    end else begin
      if (m_conf) begin
        if (bus.dl_clear) begin m_conf = 0; m_run = 0; end
      end else if (raw) begin
        m_run++;
        if (m_run >= int'(CC)) begin m_conf = 1; m_snap = sel; m_stamp = m_cyc; end
      end else begin
        m_run = 0;
      end
      m_dep_reg = (bus.proc_dep_vld_vec != 0) ? sel : '0;
      m_tok = (((bus.token_in_vec != 0) && !bus.token_clear) || bus.origin)
              ? bus.proc_dep_vld_vec : '0;
      m_cyc = m_cyc + SW'(1);
    end
    #1;
    check("detect", 64'(bus.dl_detect_out), 64'(m_conf));
    check("snapshot", 64'(bus.dl_dep_snapshot), 64'(m_snap));
    check("token_out", 64'(bus.token_out_vec), 64'(m_tok));
    check("dep_data", 64'(bus.out_chan_dep_data), 64'(m_dep_reg | PN'(1 << PID)));
    check("dep_vld", 64'(bus.out_chan_dep_vld_vec), 64'(bus.proc_dep_vld_vec));
`ifdef DL_MONITOR_CYCLE_STAMP_EN
    check("stamp", 64'(bus.dl_cycle_stamp), 64'(m_stamp));
`else
    check("stamp", 64'(bus.dl_cycle_stamp), 64'(0));
`endif
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive_raw(bit on);
    bus.proc_dep_vld_vec     = 3'b001;
    bus.in_chan_dep_vld_vec  = on ? 2'b01 : 2'b00;
    bus.in_chan_dep_data_vec = 8'b0000_0001;
  endtask

  initial begin
    reset = 1'b1;
    bus.proc_dep_vld_vec = '0; bus.in_chan_dep_vld_vec = '0; bus.in_chan_dep_data_vec = '0;
    bus.token_in_vec = '0; bus.dl_detect_in = 1'b0; bus.origin = 1'b0;
    bus.token_clear = 1'b0; bus.dl_clear = 1'b0;
    model_reset();
    steps(2);
    reset = 1'b0;
    check("rst_detect", 64'(bus.dl_detect_out), 64'(0));
    check("rst_snapshot", 64'(bus.dl_dep_snapshot), 64'(0));
    check("rst_token", 64'(bus.token_out_vec), 64'(0));

    // No valid inputs: only own bit advertised, never detects.
    drive_raw(0);
    step();
    check("t1_dep_data", 64'(bus.out_chan_dep_data), 64'(4'b0001));
    steps(20);
    check("t1_no_detect", 64'(bus.dl_detect_out), 64'(0));

    // Confirmation exactly at the 16th edge.
    drive_raw(1);
    steps(15);
    check("t2_edge15", 64'(bus.dl_detect_out), 64'(0));
    step();
    check("t2_edge16", 64'(bus.dl_detect_out), 64'(1));
    check("t2_snapshot", 64'(bus.dl_dep_snapshot), 64'(4'b0001));

    // Clear while raw stays high, then reconfirm.
    bus.dl_clear = 1'b1;
    step();
    bus.dl_clear = 1'b0;
    check("t4_cleared", 64'(bus.dl_detect_out), 64'(0));
    steps(15);
    check("t4_edge15", 64'(bus.dl_detect_out), 64'(0));
    step();
    check("t4_reconf", 64'(bus.dl_detect_out), 64'(1));

    // Interrupted run restarts the count.
    bus.dl_clear = 1'b1; drive_raw(0); step(); bus.dl_clear = 1'b0;
    drive_raw(1); steps(9);
    drive_raw(0); step();
    drive_raw(1); steps(15);
    check("t3_restart15", 64'(bus.dl_detect_out), 64'(0));
    step();
    check("t3_restart16", 64'(bus.dl_detect_out), 64'(1));

    // Token forwarding: token_clear suppresses, origin overrides.
    bus.dl_clear = 1'b1; drive_raw(0); step(); bus.dl_clear = 1'b0;
    bus.proc_dep_vld_vec = 3'b101; bus.token_in_vec = 2'b01; bus.token_clear = 1'b1;
    step();
    check("t5_suppressed", 64'(bus.token_out_vec), 64'(0));
    bus.origin = 1'b1;
    step();
    check("t5_origin", 64'(bus.token_out_vec), 64'(3'b101));
    bus.origin = 1'b0; bus.token_clear = 1'b0; bus.token_in_vec = '0;

    // Reset mid-count discards progress.
    drive_raw(1); steps(8);
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_mid_detect", 64'(bus.dl_detect_out), 64'(0));
    check("rst_mid_token", 64'(bus.token_out_vec), 64'(0));
    steps(15);
    check("rst_mid_15", 64'(bus.dl_detect_out), 64'(0));
    step();
    check("rst_mid_16", 64'(bus.dl_detect_out), 64'(1));

`ifdef DL_MONITOR_CYCLE_STAMP_EN
    reset = 1'b1; step(); reset = 1'b0;
    drive_raw(0); steps(85);
    drive_raw(1); steps(16);
    check("t6_stamp100", 64'(bus.dl_cycle_stamp), 64'(100));
`endif

    // Biased random traffic: alternate "hot" stretches that can confirm with noisy ones.
    begin
      bit hot = 0;
      for (int c = 0; c < 2000; c++) begin
        if (c % 40 == 0) hot = ($urandom_range(0, 1) == 1);
        bus.proc_dep_vld_vec     = ($urandom_range(0, 7) == 0) ? '0 : OC'($urandom_range(1, 7));
        bus.in_chan_dep_vld_vec  = IC'($urandom);
        bus.in_chan_dep_data_vec = DW'($urandom);
        bus.token_in_vec         = IC'($urandom);
        bus.dl_detect_in         = ($urandom_range(0, 3) == 0);
        bus.origin               = ($urandom_range(0, 3) == 0);
        bus.token_clear          = ($urandom_range(0, 1) == 1);
        bus.dl_clear             = ($urandom_range(0, 29) == 0);
        if (hot) begin
          bus.proc_dep_vld_vec[0]     = 1'b1;
          bus.in_chan_dep_vld_vec[0]  = 1'b1;
          bus.in_chan_dep_data_vec[PID] = 1'b1;
          bus.dl_detect_in            = 1'b0;
        end
        reset = ($urandom_range(0, 299) == 0);
        step();
      end
      reset = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
